// File: rtl/column_drop_ctrl.sv
// Column-drop controller: cursor movement, per-column fill tracking, player
// alternation and a valid/ready drop request towards the board store.
module column_drop_ctrl #(
   parameter int COLS = 7,
   parameter int ROWS = 6,
   parameter bit WRAP = 1'b1,
   localparam int CW = $clog2(COLS),
   localparam int RW = $clog2(ROWS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_left_pulse,
   input  logic          i_right_pulse,
   input  logic          i_confirm_pulse,
   input  logic          i_drop_ready,
   output logic          o_drop_valid,
   output logic [CW-1:0] o_drop_col,
   output logic [RW-1:0] o_drop_row,
   output logic          o_drop_player,
   output logic [CW-1:0] o_cursor_col,
   output logic          o_cur_player,
   output logic          o_col_full_err,
   output logic          o_board_full
);

   localparam int TOTAL = COLS * ROWS;
   localparam int NW    = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t                     r_state, w_state_nxt;
   logic [COLS-1:0][RW-1:0]    r_height, w_height_nxt;
   logic [NW-1:0]              r_count, w_count_nxt;
   logic [CW-1:0]              r_cursor, w_cursor_nxt;
   logic                       r_player, w_player_nxt;
   logic                       r_drop_valid, w_drop_valid_nxt;
   logic [CW-1:0]              r_drop_col, w_drop_col_nxt;
   logic [RW-1:0]              r_drop_row, w_drop_row_nxt;
   logic                       r_drop_player, w_drop_player_nxt;
   logic                       r_col_full_err, w_col_full_err_nxt;
   logic                       r_board_full, w_board_full_nxt;

   logic                       w_commit;
   logic                       w_cur_full;
   logic [NW-1:0]              w_count_inc;
   logic                       w_last;
   logic                       w_move_left;
   logic                       w_move_right;

   assign w_commit     = (r_state == S_REQ) && r_drop_valid && i_drop_ready;
   assign w_cur_full   = (r_height[r_cursor] == RW'(ROWS));
   assign w_count_inc  = r_count + NW'(1);
   assign w_last       = (w_count_inc == NW'(TOTAL));
   // Confirm outranks movement; simultaneous left+right cancel each other.
   assign w_move_left  = (r_state == S_IDLE) && !i_confirm_pulse && i_left_pulse && !i_right_pulse;
   assign w_move_right = (r_state == S_IDLE) && !i_confirm_pulse && i_right_pulse && !i_left_pulse;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_confirm_pulse && !w_cur_full) w_state_nxt = S_REQ;
         S_REQ:   if (w_commit) w_state_nxt = w_last ? S_DONE : S_IDLE;
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_height_nxt       = r_height;
      w_count_nxt        = r_count;
      w_cursor_nxt       = r_cursor;
      w_player_nxt       = r_player;
      w_drop_valid_nxt   = r_drop_valid;
      w_drop_col_nxt     = r_drop_col;
      w_drop_row_nxt     = r_drop_row;
      w_drop_player_nxt  = r_drop_player;
      w_col_full_err_nxt = 1'b0;
      w_board_full_nxt   = r_board_full;

      if (w_move_left) begin
         if (r_cursor == '0) w_cursor_nxt = WRAP ? CW'(COLS - 1) : r_cursor;
         else                w_cursor_nxt = r_cursor - CW'(1);
      end else if (w_move_right) begin
         if (r_cursor == CW'(COLS - 1)) w_cursor_nxt = WRAP ? '0 : r_cursor;
         else                           w_cursor_nxt = r_cursor + CW'(1);
      end

      if ((r_state == S_IDLE) && i_confirm_pulse) begin
         if (w_cur_full) begin
            w_col_full_err_nxt = 1'b1;
         end else begin
            w_drop_valid_nxt  = 1'b1;
            w_drop_col_nxt    = r_cursor;
            w_drop_row_nxt    = r_height[r_cursor];
            w_drop_player_nxt = r_player;
         end
      end

      if (w_commit) begin
         w_drop_valid_nxt         = 1'b0;
         w_height_nxt[r_drop_col] = r_height[r_drop_col] + RW'(1);
         w_player_nxt             = ~r_player;
         w_count_nxt              = w_count_inc;
         if (w_last) w_board_full_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_height       <= '0;
         r_count        <= '0;
         r_cursor       <= CW'(COLS / 2);
         r_player       <= 1'b0;
         r_drop_valid   <= 1'b0;
         r_drop_col     <= '0;
         r_drop_row     <= '0;
         r_drop_player  <= 1'b0;
         r_col_full_err <= 1'b0;
         r_board_full   <= 1'b0;
      end else begin
         r_height       <= w_height_nxt;
         r_count        <= w_count_nxt;
         r_cursor       <= w_cursor_nxt;
         r_player       <= w_player_nxt;
         r_drop_valid   <= w_drop_valid_nxt;
         r_drop_col     <= w_drop_col_nxt;
         r_drop_row     <= w_drop_row_nxt;
         r_drop_player  <= w_drop_player_nxt;
         r_col_full_err <= w_col_full_err_nxt;
         r_board_full   <= w_board_full_nxt;
      end
   end

   assign o_drop_valid   = r_drop_valid;
   assign o_drop_col     = r_drop_col;
   assign o_drop_row     = r_drop_row;
   assign o_drop_player  = r_drop_player;
   assign o_cursor_col   = r_cursor;
   assign o_cur_player   = r_player;
   assign o_col_full_err = r_col_full_err;
   assign o_board_full   = r_board_full;

endmodule

// File: tb/tb_column_drop_ctrl.sv
// Bench for column_drop_ctrl: directed scenarios plus a random fill, all
// outputs compared every cycle against a game-level reference model.
module tb_column_drop_ctrl;
   localparam int COLS = 7;
   localparam int ROWS = 6;

   logic clk = 1'b0;
   logic reset = 1'b0, lp = 1'b0, rp = 1'b0, cp = 1'b0, rdy = 1'b0;
   logic       dv, dp, pl, err, bf;
   logic [2:0] dc, dr, cc;
   logic       dv0, dp0, pl0, err0, bf0;
   logic [2:0] dc0, dr0, cc0;

   int checks = 0;
   int errors = 0;

   // reference model (WRAP=1 instance)
   int m_h[COLS];
   int m_cur, m_pl, m_cnt, m_dc, m_dr, m_dp;
   bit m_pend, m_done, m_err;

   always #5 clk = ~clk;

   column_drop_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(1'b1)) u_dut (
      .clk(clk), .reset(reset), .i_left_pulse(lp), .i_right_pulse(rp),
      .i_confirm_pulse(cp), .i_drop_ready(rdy), .o_drop_valid(dv),
      .o_drop_col(dc), .o_drop_row(dr), .o_drop_player(dp),
      .o_cursor_col(cc), .o_cur_player(pl), .o_col_full_err(err),
      .o_board_full(bf));

   column_drop_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(1'b0)) u_dut_sat (
      .clk(clk), .reset(reset), .i_left_pulse(lp), .i_right_pulse(rp),
      .i_confirm_pulse(cp), .i_drop_ready(rdy), .o_drop_valid(dv0),
      .o_drop_col(dc0), .o_drop_row(dr0), .o_drop_player(dp0),
      .o_cursor_col(cc0), .o_cur_player(pl0), .o_col_full_err(err0),
      .o_board_full(bf0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit rs, input bit l, input bit r, input bit c, input bit rd);
      if (rs) begin
         foreach (m_h[i]) m_h[i] = 0;
         m_cur = COLS / 2; m_pl = 0; m_cnt = 0;
         m_dc = 0; m_dr = 0; m_dp = 0;
         m_pend = 0; m_done = 0; m_err = 0;
         return;
      end
      m_err = 0;
      if (m_done) return;
      if (m_pend) begin
         if (rd) begin
            m_h[m_dc]++;
            m_pl = 1 - m_pl;
            m_cnt++;
            m_pend = 0;
            if (m_cnt == COLS * ROWS) m_done = 1;
         end
      end else if (c) begin
         if (m_h[m_cur] == ROWS) m_err = 1;
         else begin
            m_pend = 1; m_dc = m_cur; m_dr = m_h[m_cur]; m_dp = m_pl;
         end
      end else if (l && !r) begin
         m_cur = (m_cur + COLS - 1) % COLS;
      end else if (r && !l) begin
         m_cur = (m_cur + 1) % COLS;
      end
   endtask

   task automatic check_all();
      chk("drop_valid", dv, m_pend);
      chk("drop_col", dc, m_dc);
      chk("drop_row", dr, m_dr);
      chk("drop_player", dp, m_dp);
      chk("cursor_col", cc, m_cur);
      chk("cur_player", pl, m_pl);
      chk("col_full_err", err, m_err);
      chk("board_full", bf, m_done);
   endtask

   task automatic cyc(input bit rs, input bit l, input bit r, input bit c, input bit rd);
      reset = rs; lp = l; rp = r; cp = c; rdy = rd;
      @(posedge clk);
      model_step(rs, l, r, c, rd);
      #1;
      check_all();
   endtask

   initial begin
      int guard;
      int x;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rst_cursor", cc, 3);
      chk("rst_cursor_sat", cc0, 3);

      // cursor wrap vs saturate
      repeat (3) cyc(0, 0, 1, 0, 0);
      chk("right_to_edge", cc, 6);
      cyc(0, 0, 1, 0, 0);
      chk("wrap_right", cc, 0);
      chk("sat_right", cc0, 6);
      repeat (6) cyc(0, 1, 0, 0, 0);
      chk("sat_walk_left", cc0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("sat_left", cc0, 0);
      chk("wrap_left_pos", cc, 0);
      repeat (3) cyc(0, 0, 1, 0, 0);
      chk("back_to_3", cc, 3);

      // held request with back-pressure
      cyc(0, 0, 0, 1, 0);
      repeat (4) begin
         cyc(0, 0, 0, 0, 0);
         chk("hold_valid", dv, 1);
         chk("hold_col", dc, 3);
      end
      cyc(0, 0, 0, 0, 1);
      chk("commit_player", pl, 1);
      chk("commit_valid", dv, 0);

      // fill column 0, then overflow confirm
      repeat (3) cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < ROWS; i++) begin
         cyc(0, 0, 0, 1, 1);
         chk("col0_row", dr, i);
         cyc(0, 0, 0, 0, 1);
      end
      cyc(0, 0, 0, 1, 0);
      chk("full_err_pulse", err, 1);
      chk("full_err_no_valid", dv, 0);
      cyc(0, 0, 0, 0, 0);
      chk("full_err_clear", err, 0);

      // left+right cancel; pulses ignored while requesting
      cyc(0, 1, 1, 0, 0);
      chk("lr_cancel", cc, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 1);
      chk("req_ignore_cursor", cc, 1);

      // random play until the board is full
      guard = 0;
      while (!m_done && guard < 20000) begin
         guard++;
         x = $urandom_range(0, 9);
         cyc(0, x < 3 || x == 9, (x >= 3 && x < 6) || x == 9, x >= 6 && x < 9,
             1'($urandom_range(0, 1)));
      end
      checks++;
      assert (guard < 20000) else begin
         errors++;
         $error("FAIL fill_budget observed=%0d expected<%0d", guard, 20000);
      end
      chk("board_full_set", bf, 1);
      repeat (6) begin
         cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1);
         chk("done_no_valid", dv, 0);
         chk("done_no_err", err, 0);
         chk("done_full", bf, 1);
      end

      // reset during a pending handshake
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      chk("pre_rst_valid", dv, 1);
      cyc(1, 0, 0, 0, 0);
      chk("rst_mid_valid", dv, 0);
      chk("rst_mid_cursor", cc, 3);
      chk("rst_mid_player", pl, 0);
      cyc(0, 0, 0, 1, 0);
      chk("rst_mid_row", dr, 0);
      cyc(0, 0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
